icache: RTL and testbench

// - Direct-mapped instruction cache; responder side of the fetch I-cache interface (ic_req_* in, ic_rsp_* out).
// - Hit: returns the 32-bit instruction one cycle after the request. Miss: refills a full line from memory, then responds.
// - Sits between fetch and the memory/bus fabric.

---
 rtl/icache.sv | 172 +++++++++++++++++
 tb/tb_icache.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache with line refill from memory.
// Optional hit/miss counters are enabled by defining ICACHE_STATS_EN.
module icache #(
    parameter int LINES      = 64,
    parameter int LINE_WORDS = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        ic_req_valid_i,
    input  logic [31:0] ic_req_addr_i,
    output logic        ic_rsp_valid_o,
    output logic [31:0] ic_rsp_data_o,
    input  logic        flush_i,
    output logic        mem_req_valid_o,
    input  logic        mem_req_ready_i,
    output logic [31:0] mem_req_addr_o,
    input  logic        mem_rsp_valid_i,
    input  logic [31:0] mem_rsp_data_i
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_cnt_o,
    output logic [31:0] miss_cnt_o
`endif
);

    localparam int WORD_W = $clog2(LINE_WORDS);
    localparam int OFF_W  = WORD_W + 2;
    localparam int IDX_W  = $clog2(LINES);
    localparam int TAG_W  = 32 - IDX_W - OFF_W;
    localparam int AW     = IDX_W + WORD_W;

    typedef enum logic [1:0] {IDLE, MISS_REQ, MISS_WAIT, RESP} state_t;

    state_t state_reg, state_next;

    logic [TAG_W-1:0] tag_mem  [LINES];
    logic [31:0]      data_mem [LINES*LINE_WORDS];
    logic [31:0]      ram_q;

    logic [LINES-1:0] valid_reg, valid_next;
    logic [31:2]      miss_addr_reg;
    logic [31:0]      mem_req_addr_reg;
    logic [WORD_W-1:0] cnt_reg;
    logic             drop_reg;
    logic             flush_seen_reg;
    logic [31:0]      word_reg;
    logic [31:0]      hold_reg;
    logic             out_sel_reg;
    logic             rsp_valid_reg;

    logic [TAG_W-1:0]  req_tag, miss_tag;
    logic [IDX_W-1:0]  req_idx, miss_idx;
    logic [WORD_W-1:0] req_word, miss_word;
    logic hit, hit_acc, miss_acc, beat, last_beat, in_refill, drop_now, deliver;
    logic unused_addr_bits;

    assign req_tag   = ic_req_addr_i[31:IDX_W+OFF_W];
    assign req_idx   = ic_req_addr_i[IDX_W+OFF_W-1:OFF_W];
    assign req_word  = ic_req_addr_i[OFF_W-1:2];
    assign miss_tag  = miss_addr_reg[31:IDX_W+OFF_W];
    assign miss_idx  = miss_addr_reg[IDX_W+OFF_W-1:OFF_W];
    assign miss_word = miss_addr_reg[OFF_W-1:2];
    assign unused_addr_bits = ^ic_req_addr_i[1:0];

    // A flush in the same cycle as a lookup forces a miss.
    assign hit       = valid_reg[req_idx] && (tag_mem[req_idx] == req_tag) && !flush_i;
    assign in_refill = (state_reg == MISS_REQ) || (state_reg == MISS_WAIT);
    assign drop_now  = drop_reg || !ic_req_valid_i;

    always_comb begin
        state_next = state_reg;
        hit_acc    = 1'b0;
        miss_acc   = 1'b0;
        beat       = 1'b0;
        last_beat  = 1'b0;
        case (state_reg)
            IDLE: begin
                hit_acc  = ic_req_valid_i && hit;
                miss_acc = ic_req_valid_i && !hit;
                if (miss_acc) state_next = MISS_REQ;
            end
            MISS_REQ: begin
                if (mem_req_ready_i) state_next = MISS_WAIT;
            end
            MISS_WAIT: begin
                beat      = mem_rsp_valid_i;
                last_beat = beat && (cnt_reg == WORD_W'(LINE_WORDS - 1));
                if (last_beat) state_next = drop_now ? IDLE : RESP;
            end
            RESP: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign deliver = last_beat && !drop_now;

    genvar gi;
    generate
        for (gi = 0; gi < LINES; gi++) begin : g_valid
            // The refilled line only becomes valid if no flush hit it mid-refill.
            assign valid_next[gi] = flush_i ? 1'b0 :
                                    (last_beat && !flush_seen_reg && (miss_idx == IDX_W'(gi))) ? 1'b1 :
                                    valid_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (beat) data_mem[{miss_idx, cnt_reg}] <= mem_rsp_data_i;
        if (hit_acc) ram_q <= data_mem[{req_idx, req_word}];
        if (last_beat) tag_mem[miss_idx] <= miss_tag;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg        <= IDLE;
            valid_reg        <= '0;
            miss_addr_reg    <= '0;
            mem_req_addr_reg <= '0;
            cnt_reg          <= '0;
            drop_reg         <= 1'b0;
            flush_seen_reg   <= 1'b0;
            word_reg         <= '0;
            hold_reg         <= '0;
            out_sel_reg      <= 1'b0;
            rsp_valid_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            valid_reg <= valid_next;
            if (miss_acc) begin
                miss_addr_reg    <= ic_req_addr_i[31:2];
                mem_req_addr_reg <= {ic_req_addr_i[31:OFF_W], {OFF_W{1'b0}}};
                drop_reg         <= 1'b0;
                flush_seen_reg   <= 1'b0;
            end else begin
                if (in_refill && !ic_req_valid_i) drop_reg <= 1'b1;
                if (in_refill && flush_i) flush_seen_reg <= 1'b1;
            end
            if (state_reg == MISS_REQ) cnt_reg <= '0;
            else if (beat) cnt_reg <= cnt_reg + WORD_W'(1);
            if (beat && (cnt_reg == miss_word)) word_reg <= mem_rsp_data_i;
            rsp_valid_reg <= hit_acc || deliver;
            // Output data comes from the RAM after a hit, or from the captured beat after a refill.
            if (hit_acc) begin
                out_sel_reg <= 1'b1;
            end else if (deliver) begin
                out_sel_reg <= 1'b0;
                hold_reg    <= (cnt_reg == miss_word) ? mem_rsp_data_i : word_reg;
            end
        end
    end

    assign ic_rsp_valid_o  = rsp_valid_reg;
    assign ic_rsp_data_o   = out_sel_reg ? ram_q : hold_reg;
    assign mem_req_valid_o = (state_reg == MISS_REQ);
    assign mem_req_addr_o  = mem_req_addr_reg;

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt_reg, miss_cnt_reg;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hit_cnt_reg  <= '0;
            miss_cnt_reg <= '0;
        end else begin
            if (hit_acc && (hit_cnt_reg != 32'hFFFF_FFFF)) hit_cnt_reg <= hit_cnt_reg + 32'd1;
            if (miss_acc && (miss_cnt_reg != 32'hFFFF_FFFF)) miss_cnt_reg <= miss_cnt_reg + 32'd1;
        end
    end
    assign hit_cnt_o  = hit_cnt_reg;
    assign miss_cnt_o = miss_cnt_reg;
`endif

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: transaction-level cache model plus a per-cycle output compare.
module tb_icache;
    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        ic_req_valid_i = 1'b0;
    logic [31:0] ic_req_addr_i = '0;
    logic        ic_rsp_valid_o;
    logic [31:0] ic_rsp_data_o;
    logic        flush_i = 1'b0;
    logic        mem_req_valid_o;
    logic        mem_req_ready_i = 1'b0;
    logic [31:0] mem_req_addr_o;
    logic        mem_rsp_valid_i = 1'b0;
    logic [31:0] mem_rsp_data_i = '0;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt_o, miss_cnt_o;
`endif

    icache dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .ic_req_valid_i(ic_req_valid_i), .ic_req_addr_i(ic_req_addr_i),
        .ic_rsp_valid_o(ic_rsp_valid_o), .ic_rsp_data_o(ic_rsp_data_o),
        .flush_i(flush_i),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
        .mem_req_addr_o(mem_req_addr_o),
        .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rsp_data_i(mem_rsp_data_i)
`ifdef ICACHE_STATS_EN
        , .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_pass   = 0;
    int n_hits   = 0;
    int n_misses = 0;

    // Cache model: 64 lines x 4 words.
    bit          mv [64];
    logic [31:0] mt [64];
    logic [31:0] md [256];

    logic        exp_rsp_valid = 1'b0;
    logic [31:0] exp_rsp_data = '0;
    logic        exp_mem_req_valid = 1'b0;
    logic [31:0] exp_mem_req_addr = '0;
    logic        nxt_rsp_valid = 1'b0;
    logic [31:0] nxt_rsp_data = '0;
    bit          last_hit;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] x);
        return 32'hA0 + ((x - 32'h100) >> 2);
    endfunction

    always @(negedge clk_i) begin
        check("rsp_valid", {31'd0, ic_rsp_valid_o}, {31'd0, exp_rsp_valid});
        check("rsp_data", ic_rsp_data_o, exp_rsp_data);
        check("mem_req_valid", {31'd0, mem_req_valid_o}, {31'd0, exp_mem_req_valid});
        if (exp_mem_req_valid) check("mem_req_addr", mem_req_addr_o, exp_mem_req_addr);
    end

    task automatic step();
        @(posedge clk_i);
        #1;
        exp_rsp_valid = nxt_rsp_valid;
        if (nxt_rsp_valid) exp_rsp_data = nxt_rsp_data;
        nxt_rsp_valid = 1'b0;
    endtask

    task automatic clear_valid();
        for (int i = 0; i < 64; i++) mv[i] = 1'b0;
    endtask

    // One fetch transaction; negative beat numbers disable cancel/flush.
    task automatic access(input logic [31:0] a, input int rdy_wait, input int cancel_beat,
                          input int flush_beat, input bit flush_req);
        int idx, w;
        logic [31:0] tag, line, d;
        bit dropped, flushed;
        idx  = int'((a >> 4) & 32'h3F);
        w    = int'((a >> 2) & 32'h3);
        tag  = a >> 10;
        line = a & ~32'hF;
        ic_req_valid_i = 1'b1;
        ic_req_addr_i  = a;
        flush_i        = flush_req;
        if (flush_req) clear_valid();
        last_hit = mv[idx] && (mt[idx] == tag);
        $display("txn addr=%h %s", a, last_hit ? "hit" : "miss");
        if (last_hit) begin
            n_hits++;
            nxt_rsp_valid = 1'b1;
            nxt_rsp_data  = md[idx*4 + w];
            step();
            ic_req_valid_i = 1'b0;
            flush_i = 1'b0;
            return;
        end
        n_misses++;
        step();
        flush_i = 1'b0;
        exp_mem_req_valid = 1'b1;
        exp_mem_req_addr  = line;
        for (int i = 0; i < rdy_wait; i++) begin
            mem_rsp_valid_i = 1'b1;
            mem_rsp_data_i  = 32'hDEAD_0000 + i;
            step();
        end
        mem_rsp_valid_i = 1'b0;
        mem_req_ready_i = 1'b1;
        step();
        mem_req_ready_i   = 1'b0;
        exp_mem_req_valid = 1'b0;
        dropped = 1'b0;
        flushed = 1'b0;
        for (int b = 0; b < 4; b++) begin
            if (b == cancel_beat) begin ic_req_valid_i = 1'b0; dropped = 1'b1; end
            if (b == flush_beat) begin flush_i = 1'b1; flushed = 1'b1; clear_valid(); end
            d = mem_word(line + 32'(4*b));
            mem_rsp_valid_i = 1'b1;
            mem_rsp_data_i  = d;
            md[idx*4 + b]   = d;
            if (b == 3 && !dropped) begin
                nxt_rsp_valid = 1'b1;
                nxt_rsp_data  = mem_word(a & ~32'h3);
            end
            step();
            flush_i = 1'b0;
            mem_rsp_valid_i = 1'b0;
            if (b == 1) step();
        end
        mt[idx] = tag;
        mv[idx] = !flushed;
        ic_req_valid_i = 1'b0;
        if (!dropped) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        clear_valid();
        #1;
        step();
        step();
        check("reset rsp_valid", {31'd0, ic_rsp_valid_o}, 32'd0);
        check("reset rsp_data", ic_rsp_data_o, 32'd0);
        check("reset mem_req_valid", {31'd0, mem_req_valid_o}, 32'd0);
        check("reset mem_req_addr", mem_req_addr_o, 32'd0);
        rst_ni = 1'b1;
        step();

        // Cold miss with one cycle of backpressure and spurious beats while waiting.
        access(32'h100, 1, -1, -1, 1'b0);
        check("cold miss data", ic_rsp_data_o, 32'hA0);
        check("cold miss is miss", {31'd0, last_hit}, 32'd0);

        // Back-to-back hits.
        access(32'h104, 0, -1, -1, 1'b0);
        check("hit 104", ic_rsp_data_o, 32'hA1);
        access(32'h108, 0, -1, -1, 1'b0);
        check("hit 108", ic_rsp_data_o, 32'hA2);
        access(32'h10C, 0, -1, -1, 1'b0);
        check("hit 10C", ic_rsp_data_o, 32'hA3);
        check("hit 10C valid", {31'd0, ic_rsp_valid_o}, 32'd1);
        step();

        // Conflict on index 16, then the evicted line misses again.
        access(32'h500, 2, -1, -1, 1'b0);
        check("conflict data", ic_rsp_data_o, 32'h1A0);
        access(32'h100, 0, -1, -1, 1'b0);
        check("evicted miss", {31'd0, last_hit}, 32'd0);
        check("refetch data", ic_rsp_data_o, 32'hA0);

        // Cancel during refill: no response, line still installed.
        access(32'h200, 0, 2, -1, 1'b0);
        step();
        access(32'h204, 0, -1, -1, 1'b0);
        check("post-cancel hit", {31'd0, last_hit}, 32'd1);
        check("post-cancel data", ic_rsp_data_o, 32'hE1);
        step();

        // Flush mid-refill: response delivered, line not valid afterwards.
        access(32'h300, 0, -1, 1, 1'b0);
        check("flush refill data", ic_rsp_data_o, 32'h120);
        access(32'h300, 0, -1, -1, 1'b0);
        check("after flush miss", {31'd0, last_hit}, 32'd0);
        access(32'h304, 0, -1, -1, 1'b0);
        check("refilled hit", ic_rsp_data_o, 32'h121);

        // Flush with same-cycle request forces a miss.
        access(32'h308, 0, -1, -1, 1'b1);
        check("flush req miss", {31'd0, last_hit}, 32'd0);
        check("flush req data", ic_rsp_data_o, 32'h122);

        // Reset while in MISS_REQ.
        ic_req_valid_i = 1'b1;
        ic_req_addr_i  = 32'h900;
        $display("txn addr=%h miss then reset", ic_req_addr_i);
        step();
        exp_mem_req_valid = 1'b1;
        exp_mem_req_addr  = 32'h900;
        #1 rst_ni = 1'b0;
        #1 check("reset mid-refill mem_req_valid", {31'd0, mem_req_valid_o}, 32'd0);
        exp_mem_req_valid = 1'b0;
        exp_rsp_valid     = 1'b0;
        exp_rsp_data      = '0;
        nxt_rsp_valid     = 1'b0;
        ic_req_valid_i    = 1'b0;
        clear_valid();
        n_hits = 0;
        n_misses = 0;
        step();
        step();
        rst_ni = 1'b1;
        step();
        access(32'h900, 0, -1, -1, 1'b0);
        check("post-reset miss", {31'd0, last_hit}, 32'd0);
        access(32'h90C, 0, -1, -1, 1'b0);
        check("post-reset hit data", ic_rsp_data_o, mem_word(32'h90C));
        step();
        step();
`ifdef ICACHE_STATS_EN
        check("hit_cnt", hit_cnt_o, 32'(n_hits));
        check("miss_cnt", miss_cnt_o, 32'(n_misses));
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
